// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle.
// Purpose: groups the instruction-memory handshake (req/addr/gnt/rvalid/rdata),
//          the decoder-facing instruction stream (valid/instruction/pc/ready),
//          the redirect request (redirect/target_pc) and the fetch enable.
// Modports:
//   master - the fetch unit (drives imem_req/imem_addr and the instruction stream)
//   slave  - the environment (memory + decoder) facing the fetch unit
interface instr_fetch_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    fetch_en;
    logic                    imem_req;
    logic [ADDRESS_BITS-1:0] imem_addr;
    logic                    imem_gnt;
    logic                    imem_rvalid;
    logic [31:0]             imem_rdata;
    logic                    instr_valid;
    logic [31:0]             instruction;
    logic [ADDRESS_BITS-1:0] pc;
    logic                    instr_ready;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] target_pc;

    modport master (
        input  fetch_en,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instruction, pc,
        input  instr_ready, redirect, target_pc
    );

    modport slave (
        output fetch_en,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instruction, pc,
        output instr_ready, redirect, target_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Purpose: issues sequential word fetches over a req/gnt/rvalid handshake (up to
//          MAX_OUTSTANDING in flight), buffers responses in a small prefetch queue
//          that feeds the decoder, and handles redirects by flushing the queue and
//          discarding responses that were already in flight.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instr_fetch_if.master: fetch_en, imem_* handshake, instruction stream,
//           redirect/target_pc
module instr_fetch #(
    parameter int                      ADDRESS_BITS    = 16,
    parameter logic [ADDRESS_BITS-1:0] BOOT_ADDR       = '0,
    parameter int                      MAX_OUTSTANDING = 2,
    parameter int                      FIFO_DEPTH      = 2
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    localparam int AB  = ADDRESS_BITS;
    localparam int CW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int QPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C     = CW'(MAX_OUTSTANDING);
    localparam logic [AB-1:0] ALIGN_MASK = {{(AB-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
        return (p == QPW'(FIFO_DEPTH - 1)) ? '0 : p + QPW'(1);
    endfunction

    function automatic logic [OPW-1:0] o_inc(input logic [OPW-1:0] p);
        return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + OPW'(1);
    endfunction

    state_t          state_q, state_d;
    logic [AB-1:0]   fetch_pc_q, fetch_pc_d;
    logic            pend_q, pend_d;          // request on the bus, not yet granted
    logic [AB-1:0]   pend_addr_q, pend_addr_d;
    logic            stale_q, stale_d;        // pending request predates a redirect
    logic [CW-1:0]   out_q, out_d;            // granted, response not yet seen
    logic [CW-1:0]   disc_q, disc_d;          // responses still to be dropped
    logic [CW-1:0]   occ_q, occ_d;            // prefetch queue occupancy
    logic [QPW-1:0]  q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [OPW-1:0]  o_rd_q, o_rd_d, o_wr_q, o_wr_d;
    logic            boot_rdir_q, boot_rdir_d;
    logic [AB-1:0]   boot_tgt_q, boot_tgt_d;
    logic [AB-1:0]   q_pc_q  [FIFO_DEPTH];
    logic [31:0]     q_ins_q [FIFO_DEPTH];
    logic [AB-1:0]   o_addr_q[MAX_OUTSTANDING];

    logic            rdir_now, rdir_eff, pop, rsp, wr, credit_ok, issue, req, gnt_fire;
    logic [AB-1:0]   rdir_tgt, req_addr;

    // A redirect seen during BOOT is held and applied in the first RUN cycle.
    assign rdir_now = bus.redirect && (state_q != S_BOOT);
    assign rdir_eff = rdir_now || (boot_rdir_q && (state_q == S_RUN));
    assign rdir_tgt = rdir_now ? bus.target_pc : boot_tgt_q;

    assign pop = (occ_q != '0) && bus.instr_ready;
    assign rsp = bus.imem_rvalid && (out_q != '0);
    assign wr  = rsp && (disc_q == '0) && !rdir_eff;

    // Every in-flight response owns a queue slot. A pop this cycle frees a slot
    // before the grant lands, which is what allows one request per cycle.
    assign credit_ok = ((occ_q + out_q - CW'(pop)) < DEPTH_C) && (out_q < MAXO_C);

    // No fresh request in a redirect cycle: it would target the old stream.
    assign issue    = (state_q == S_RUN) && bus.fetch_en && !pend_q && !stale_q &&
                      !rdir_eff && credit_ok;
    assign req      = pend_q || issue;
    assign req_addr = pend_q ? pend_addr_q : (issue ? fetch_pc_q : '0);
    assign gnt_fire = req && bus.imem_gnt;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = req_addr;
    assign bus.instr_valid = (occ_q != '0);
    assign bus.instruction = q_ins_q[q_rd_q];
    assign bus.pc          = q_pc_q[q_rd_q];

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pend_d      = req && !bus.imem_gnt;
        pend_addr_d = req_addr;
        stale_d     = stale_q && !bus.imem_gnt;
        out_d       = out_q + CW'(gnt_fire) - CW'(rsp);
        disc_d      = disc_q - CW'(rsp && (disc_q != '0)) + CW'(gnt_fire && stale_q);
        occ_d       = occ_q + CW'(wr) - CW'(pop);
        q_rd_d      = pop ? q_inc(q_rd_q) : q_rd_q;
        q_wr_d      = wr ? q_inc(q_wr_q) : q_wr_q;
        o_rd_d      = rsp ? o_inc(o_rd_q) : o_rd_q;
        o_wr_d      = gnt_fire ? o_inc(o_wr_q) : o_wr_q;
        boot_rdir_d = boot_rdir_q;
        boot_tgt_d  = boot_tgt_q;

        // A stale grant fetches an address that is no longer fetch_pc.
        if (gnt_fire && !stale_q) begin
            fetch_pc_d = fetch_pc_q + AB'(4);
        end

        if (rdir_eff) begin
            fetch_pc_d = rdir_tgt & ALIGN_MASK;
            // Everything still in flight after this edge belongs to the old stream.
            disc_d     = out_d;
            stale_d    = pend_q && !bus.imem_gnt;
            occ_d      = '0;
            q_rd_d     = '0;
            q_wr_d     = '0;
        end

        if (state_q == S_BOOT) begin
            if (bus.redirect) begin
                boot_rdir_d = 1'b1;
                boot_tgt_d  = bus.target_pc;
            end
        end else begin
            boot_rdir_d = 1'b0;
        end

        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN:  if (!bus.fetch_en && !(pend_q && !bus.imem_gnt)) state_d = S_HALT;
            S_HALT: if (bus.fetch_en) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= BOOT_ADDR;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            stale_q     <= 1'b0;
            out_q       <= '0;
            disc_q      <= '0;
            occ_q       <= '0;
            q_rd_q      <= '0;
            q_wr_q      <= '0;
            o_rd_q      <= '0;
            o_wr_q      <= '0;
            boot_rdir_q <= 1'b0;
            boot_tgt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc_q[i]  <= '0;
                q_ins_q[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                o_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            stale_q     <= stale_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            occ_q       <= occ_d;
            q_rd_q      <= q_rd_d;
            q_wr_q      <= q_wr_d;
            o_rd_q      <= o_rd_d;
            o_wr_q      <= o_wr_d;
            boot_rdir_q <= boot_rdir_d;
            boot_tgt_q  <= boot_tgt_d;
            if (wr) begin
                q_pc_q[q_wr_q]  <= o_addr_q[o_rd_q];
                q_ins_q[q_wr_q] <= bus.imem_rdata;
            end
            if (gnt_fire) begin
                o_addr_q[o_wr_q] <= req_addr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed cycle vectors for boot, redirect and wrap
// corner cases, mid-stream reset, then randomized memory/decoder traffic checked
// against a stream-level reference model.
module tb_instr_fetch;
    localparam int AB = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDRESS_BITS(AB)) bif();

    instr_fetch #(
        .ADDRESS_BITS(AB), .BOOT_ADDR(16'h0000), .MAX_OUTSTANDING(2), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fe, rdy, gnt, rv;
        logic [15:0] raddr;
        logic        rdir;
        logic [15:0] tgt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic vec_t mk(input logic fe, rdy, gnt, rv, input logic [15:0] raddr,
                                input logic rdir, input logic [15:0] tgt,
                                input logic e_req, input logic [15:0] e_addr,
                                input logic e_vld, input logic [15:0] e_pc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.raddr = raddr;
        v.rdir = rdir; v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr;
        v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.fetch_en    = 1'b1;
        bif.instr_ready = 1'b0;
        bif.imem_gnt    = 1'b0;
        bif.imem_rvalid = 1'b0;
        bif.imem_rdata  = 32'h0;
        bif.redirect    = 1'b0;
        bif.target_pc   = 16'h0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"},   32'(bif.imem_req), 32'h0);
        check({tag, "_addr"},  32'(bif.imem_addr), 32'h0);
        check({tag, "_vld"},   32'(bif.instr_valid), 32'h0);
        check({tag, "_pc"},    32'(bif.pc), 32'h0);
        check({tag, "_instr"}, bif.instruction, 32'h0);
    endtask

    // Leaves the bench at posedge+1 of the BOOT cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_zero(tag);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, check settled outputs, advance to posedge+1.
    task automatic apply(input vec_t v, input string tag);
        bif.fetch_en    = v.fe;
        bif.instr_ready = v.rdy;
        bif.imem_gnt    = v.gnt;
        bif.imem_rvalid = v.rv;
        bif.imem_rdata  = v.rv ? mem_word(v.raddr) : 32'hDEAD_BEEF;
        bif.redirect    = v.rdir;
        bif.target_pc   = v.tgt;
        #2;
        check({tag, " req"}, 32'(bif.imem_req), 32'(v.e_req));
        if (v.e_req) check({tag, " addr"}, 32'(bif.imem_addr), 32'(v.e_addr));
        check({tag, " vld"}, 32'(bif.instr_valid), 32'(v.e_vld));
        if (v.e_vld) begin
            check({tag, " pc"}, 32'(bif.pc), 32'(v.e_pc));
            check({tag, " instr"}, bif.instruction, mem_word(v.e_pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", tag, i));
        tbl.delete();
    endtask

    logic [15:0] mq_addr[$];
    int          mq_due[$];
    logic [15:0] exp_pc;
    logic [15:0] prev_addr;
    logic        prev_hold;
    logic        rv, rdy, gnt, rdir;
    logic [15:0] tgt;
    int          out_cnt;
    int          delivered;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Boot with a 0-wait memory, then redirect while popping and receiving.
        do_reset("rst0");
        for (int k = 0; k <= 8; k++) begin
            tbl.push_back(mk(1, 1, 1, k >= 2, 16'(4 * (k - 2)), 0, 16'h0,
                             k >= 1, 16'(4 * (k - 1)), k >= 3, 16'(4 * (k - 3))));
        end
        tbl.push_back(mk(1, 1, 1, 1, 16'h001C, 1, 16'h0200, 0, 16'h0000, 1, 16'h0018));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0204, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0204, 1, 16'h0200));
        run_tbl("boot");

        // Redirect in BOOT to 0x10, two in flight, then redirect to 0x103.
        do_reset("rst1");
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0014, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 1, 16'h0103, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0014, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0104, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0104, 1, 16'h0100));
        run_tbl("rdir2");

        // Ungranted request to 0x20 held across a redirect to 0x40.
        do_reset("rst2");
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 16'h0040, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0020, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0044, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0044, 1, 16'h0040));
        run_tbl("stale");

        // Address wrap 0xFFFC -> 0x0000 (target low bits ignored), then mid-stream reset.
        do_reset("rst3");
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFC, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 1, 16'hFFFC, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFC));
        run_tbl("wrap");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        do_reset("rst4");
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000));
        run_tbl("restart");

        // Randomized traffic: the delivered stream must be target, target+4, ...
        do_reset("rst5");
        @(posedge clk);
        #1;
        exp_pc    = 16'h0000;
        out_cnt   = 0;
        delivered = 0;
        prev_hold = 1'b0;
        prev_addr = 16'h0;
        for (int c = 0; c < 4000; c++) begin
            rdy  = ((c % 250) < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
            gnt  = ($urandom_range(0, 2) != 0);
            rdir = ($urandom_range(0, 29) == 0);
            tgt  = 16'($urandom);
            rv   = (mq_addr.size() > 0) && (mq_due[0] <= c);
            bif.fetch_en    = ($urandom_range(0, 19) != 0);
            bif.instr_ready = rdy;
            bif.imem_gnt    = gnt;
            bif.redirect    = rdir;
            bif.target_pc   = tgt;
            bif.imem_rvalid = rv;
            bif.imem_rdata  = rv ? mem_word(mq_addr[0]) : $urandom;
            #2;
            if (prev_hold) begin
                check("rnd hold_req", 32'(bif.imem_req), 32'h1);
                check("rnd hold_addr", 32'(bif.imem_addr), 32'(prev_addr));
            end
            if (bif.imem_req) check("rnd addr_align", 32'(bif.imem_addr[1:0]), 32'h0);
            if (bif.imem_req && gnt) begin
                mq_addr.push_back(bif.imem_addr);
                mq_due.push_back(c + 1 + int'($urandom_range(0, 3)));
                out_cnt++;
                check("rnd inflight", 32'(out_cnt <= 2), 32'h1);
            end
            if (rv) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
                out_cnt--;
            end
            if (rdir) begin
                exp_pc = tgt & 16'hFFFC;
            end else if (bif.instr_valid && rdy) begin
                check("rnd pc", 32'(bif.pc), 32'(exp_pc));
                check("rnd instr", bif.instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 16'd4;
                delivered++;
            end
            prev_hold = bif.imem_req && !gnt;
            prev_addr = bif.imem_addr;
            @(posedge clk);
            #1;
        end
        check("rnd liveness", 32'(delivered > 200), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
